// File: rtl/hw_bus_pkg.sv
// hw_bus_pkg: shared types and constants for the hardware_* register bus initiator.
//   - hw_bus_state_e : state encoding of hw_bus_master
//   - Default*       : default bus widths and ack timeout
//   - *_SEL          : IO responder selectors (low address bits)
//   - PhaseShift*    : field positions of a phase-shift write word
package hw_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRelease,
    StResp
  } hw_bus_state_e;

  localparam int unsigned DefaultAddrW         = 28;
  localparam int unsigned DefaultDataW         = 32;
  localparam int unsigned DefaultTimeoutCycles = 255;

  localparam logic [6:0] PHASE_SHIFT_SEL = 7'b0000000;
  localparam logic [6:0] PLL_RESET_SEL   = 7'b0000001;

  localparam int unsigned PhaseShiftCounterSelLsb = 0;
  localparam int unsigned PhaseShiftCounterSelMsb = 4;
  localparam int unsigned PhaseShiftUpDownBit     = 5;

  // Builds the write word for the phase-shift responder.
  function automatic logic [DefaultDataW-1:0] phase_shift_word(input logic [4:0] counter_sel,
                                                               input logic       up_down);
    logic [DefaultDataW-1:0] w;
    w = '0;
    w[PhaseShiftCounterSelMsb:PhaseShiftCounterSelLsb] = counter_sel;
    w[PhaseShiftUpDownBit] = up_down;
    return w;
  endfunction

endpackage

// File: rtl/hw_bus_master.sv
// hw_bus_master: initiator for the hardware_* register bus.
// Takes one command at a time on a valid/ready port, runs the four-phase ready/ack handshake
// with the responder and reports the result on a single-cycle response strobe.
//
// Ports:
//   system_clk, system_reset_n      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/addr/data/sel         command payload
//   rsp_valid/rsp_data/rsp_timeout  response strobe, read data (0 for writes/timeouts), abort flag
//   busy                            transaction in flight
//   hardware_addr/data_in/data_sel/write/ready   registered bus request outputs
//   hardware_data_out/ack           responder read data and acknowledge
//
// TIMEOUT_CYCLES must be at least 2.
module hw_bus_master
  import hw_bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefaultAddrW,
  parameter int unsigned DATA_W         = DefaultDataW,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                system_clk,
  input  logic                system_reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_timeout,
  output logic                busy,
  output logic [ADDR_W-1:0]   hardware_addr,
  output logic [DATA_W-1:0]   hardware_data_in,
  input  logic [DATA_W-1:0]   hardware_data_out,
  output logic [DATA_W/8-1:0] hardware_data_sel,
  output logic                hardware_write,
  output logic                hardware_ready,
  input  logic                hardware_ack
);

  localparam int unsigned SelW   = DATA_W / 8;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(TIMEOUT_CYCLES);

  hw_bus_state_e     state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic              write_q, write_d;
  logic              ready_q, ready_d;
  // Result captured during the handshake; published to rsp_* only on entry to RESP so the
  // response outputs hold their previous value for the whole transaction.
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              cap_timeout_q, cap_timeout_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  // Low during reset and for the first cycle after release, so cmd_ready stays low in reset.
  logic              cmd_en_q;

  logic              accept;
  logic [TimerW-1:0] timer_inc;

  // A stale ack from an aborted transaction blocks the next command.
  assign cmd_ready = (state_q == StIdle) && cmd_en_q && !hardware_ack;
  assign accept    = cmd_valid && cmd_ready;
  assign timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_inc;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    sel_d         = sel_q;
    write_d       = write_q;
    ready_d       = ready_q;
    cap_data_d    = cap_data_q;
    cap_timeout_d = cap_timeout_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (accept) begin
          addr_d        = cmd_addr;
          wdata_d       = cmd_data;
          sel_d         = cmd_sel;
          write_d       = cmd_write;
          ready_d       = 1'b1;
          cap_data_d    = '0;
          cap_timeout_d = 1'b0;
          state_d       = StReq;
        end
      end
      StReq: begin
        // Ack takes priority over a timer expiry in the same cycle.
        if (hardware_ack) begin
          cap_data_d    = write_q ? '0 : hardware_data_out;
          cap_timeout_d = 1'b0;
          ready_d       = 1'b0;
          timer_d       = '0;
          state_d       = StRelease;
        end else if (timer_q == TimerLast) begin
          cap_data_d    = '0;
          cap_timeout_d = 1'b1;
          ready_d       = 1'b0;
          timer_d       = '0;
          state_d       = StRelease;
        end
      end
      StRelease: begin
        if (!hardware_ack) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = cap_data_q;
          rsp_timeout_d = cap_timeout_q;
          timer_d       = '0;
          state_d       = StResp;
        end else if (timer_q == TimerLast) begin
          // Ack never released: report an abort and leave IDLE to hold off the next command.
          rsp_valid_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          timer_d       = '0;
          state_d       = StResp;
        end
      end
      StResp: begin
        timer_d = '0;
        state_d = StIdle;
      end
      default: begin
        timer_d = '0;
        ready_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      sel_q         <= '0;
      write_q       <= 1'b0;
      ready_q       <= 1'b0;
      cap_data_q    <= '0;
      cap_timeout_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cmd_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      sel_q         <= sel_d;
      write_q       <= write_d;
      ready_q       <= ready_d;
      cap_data_q    <= cap_data_d;
      cap_timeout_q <= cap_timeout_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      cmd_en_q      <= 1'b1;
    end
  end

  assign busy              = (state_q != StIdle);
  assign rsp_valid         = rsp_valid_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_timeout       = rsp_timeout_q;
  assign hardware_addr     = addr_q;
  assign hardware_data_in  = wdata_q;
  assign hardware_data_sel = sel_q;
  assign hardware_write    = write_q;
  assign hardware_ready    = ready_q;

endmodule

// File: tb/tb_hw_bus_master.sv
// tb_hw_bus_master: self-checking bench for hw_bus_master with a configurable responder model
// and a response scoreboard.
module tb_hw_bus_master;
  import hw_bus_pkg::*;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          timeout;
  } exp_t;

  // Responder behaviours.
  localparam int RNormal = 0;
  localparam int RNever  = 1;
  localparam int RDelay  = 2;
  localparam int RStuck  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout;
  logic          busy;
  logic [AW-1:0] hw_addr;
  logic [DW-1:0] hw_data_in;
  logic [DW-1:0] hw_data_out;
  logic [3:0]    hw_sel;
  logic          hw_write;
  logic          hw_ready;
  logic          hw_ack = 1'b0;

  int            rmode = RNormal;
  int            hold_cnt = 6;
  int            rdy_cnt = 0;
  logic [DW-1:0] rdata = '0;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  hw_bus_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .system_clk(clk),
    .system_reset_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .busy(busy),
    .hardware_addr(hw_addr),
    .hardware_data_in(hw_data_in),
    .hardware_data_out(hw_data_out),
    .hardware_data_sel(hw_sel),
    .hardware_write(hw_write),
    .hardware_ready(hw_ready),
    .hardware_ack(hw_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: registers ack one cycle after seeing ready; data is only meaningful under ack.
  assign hw_data_out = hw_ack ? rdata : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    case (rmode)
      RNormal: hw_ack <= hw_ready;
      RNever:  hw_ack <= 1'b0;
      RDelay:  hw_ack <= hw_ready && (rdy_cnt >= hold_cnt);
      default: hw_ack <= 1'b1;
    endcase
    rdy_cnt <= hw_ready ? rdy_cnt + 1 : 0;
  end

  // Scoreboard: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got data=%h timeout=%b, required no response",
                 rsp_data, rsp_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_data !== mon_e.data || rsp_timeout !== mon_e.timeout) begin
          bad++;
          $display("FAIL rsp_payload: got data=%h timeout=%b, required data=%h timeout=%b",
                   rsp_data, rsp_timeout, mon_e.data, mon_e.timeout);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required all tests to complete");
    $fatal(1);
  end

  // Presents a command and waits (bounded) for acceptance; acc is the cycle of the accept edge.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] s, input logic [DW-1:0] ed, input logic et,
                       output int acc, output bit ok);
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_sel   = s;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (cmd_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    acc = cyc;
    if (ok) begin
      e.data    = ed;
      e.timeout = et;
      exp_q.push_back(e);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  // Watches one transaction until its response strobe (bounded).
  task automatic run_obs(input int acc, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] s,
                         output int rel, output int rc, output bit stable);
    rel = -1;
    rc = 0;
    stable = 1'b1;
    for (int k = 1; k <= 60 && rel < 0; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      if (hw_ready === 1'b1) rc++;
      if ((hw_ready === 1'b1 || hw_ack === 1'b1) &&
          (hw_addr !== a || hw_data_in !== d || hw_sel !== s || hw_write !== wr))
        stable = 1'b0;
      if (rsp_valid === 1'b1) rel = cyc - acc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy, hw_addr, hw_data_in, hw_sel,
         hw_write, hw_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b rv=%b rd=%h busy=%b hrdy=%b, required all zero",
               cmd_ready, rsp_valid, rsp_data, busy, hw_ready);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_read();
    int acc, rel, rc;
    bit ok, st;
    rmode = RNormal;
    rdata = 32'h0003_0001;
    issue(1'b0, {21'b0, PHASE_SHIFT_SEL}, 32'h0, 4'hF, 32'h0003_0001, 1'b0, acc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL read_accept: got no cmd_ready, required accept"); end
    run_obs(acc, 1'b0, {21'b0, PHASE_SHIFT_SEL}, 32'h0, 4'hF, rel, rc, st);
    total++;
    if (rel != 5) begin bad++; $display("FAIL read_latency: got %0d, required 5", rel); end
    total++;
    if (rc != 2) begin bad++; $display("FAIL read_ready_cycles: got %0d, required 2", rc); end
    total++;
    if (!st) begin bad++; $display("FAIL read_bus_stable: got change, required stable"); end
    @(negedge clk);
    total++;
    if (rsp_data !== 32'h0003_0001 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_hold: got data=%h rv=%b, required 00030001 0", rsp_data, rsp_valid);
    end
  endtask

  task automatic test_write();
    int acc, rel, rc;
    bit ok, st;
    rmode = RNormal;
    rdata = 32'hFFFF_FFFF;
    issue(1'b1, {21'b0, PLL_RESET_SEL}, 32'h1, 4'hF, 32'h0, 1'b0, acc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL write_accept: got no cmd_ready, required accept"); end
    run_obs(acc, 1'b1, {21'b0, PLL_RESET_SEL}, 32'h1, 4'hF, rel, rc, st);
    total++;
    if (!st) begin bad++; $display("FAIL write_bus_stable: got change, required stable"); end
    total++;
    if (rel != 5) begin bad++; $display("FAIL write_latency: got %0d, required 5", rel); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_timeout();
    int acc, rel, rc;
    bit ok, st;
    rmode = RNever;
    issue(1'b1, 28'h2, 32'h55, 4'h3, 32'h0, 1'b1, acc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL to_accept: got no cmd_ready, required accept"); end
    run_obs(acc, 1'b1, 28'h2, 32'h55, 4'h3, rel, rc, st);
    total++;
    if (rc != 8) begin bad++; $display("FAIL to_ready_cycles: got %0d, required 8", rc); end
    total++;
    if (rel != 10) begin bad++; $display("FAIL to_latency: got %0d, required 10", rel); end
    rmode = RNormal;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ack_at_expiry();
    int acc, rel, rc;
    bit ok, st;
    rmode = RDelay;
    hold_cnt = 6;
    rdata = 32'hA5A5_1234;
    issue(1'b0, 28'h0, 32'h0, 4'hF, 32'hA5A5_1234, 1'b0, acc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL exp_accept: got no cmd_ready, required accept"); end
    run_obs(acc, 1'b0, 28'h0, 32'h0, 4'hF, rel, rc, st);
    total++;
    if (rc != 8) begin bad++; $display("FAIL exp_ready_cycles: got %0d, required 8", rc); end
    total++;
    if (rel != 11) begin bad++; $display("FAIL exp_latency: got %0d, required 11", rel); end
    rmode = RNormal;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stale_ack();
    int acc, rel, rc;
    bit st, blocked;
    exp_t e;
    rmode = RStuck;
    rdata = 32'h0000_00C3;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 28'h1;
    cmd_data  = 32'h0;
    cmd_sel   = 4'hF;
    blocked = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || busy !== 1'b0) blocked = 1'b0;
    end
    total++;
    if (!blocked) begin bad++; $display("FAIL stale_block: got cmd_ready high, required 0"); end
    rmode = RNormal;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL stale_release: got cmd_ready=%b, required 1", cmd_ready);
    end
    acc = cyc;
    e.data = 32'h0000_00C3;
    e.timeout = 1'b0;
    if (cmd_ready === 1'b1) exp_q.push_back(e);
    run_obs(acc, 1'b0, 28'h1, 32'h0, 4'hF, rel, rc, st);
    total++;
    if (rel != 5) begin bad++; $display("FAIL stale_latency: got %0d, required 5", rel); end
  endtask

  task automatic test_reset_mid();
    int acc, rel, rc, rv;
    bit ok, st;
    rmode = RNever;
    issue(1'b0, 28'h3, 32'h0, 4'hF, 32'h0, 1'b0, acc, ok);
    repeat (3) @(negedge clk);
    total++;
    if (hw_ready !== 1'b1) begin bad++; $display("FAIL mid_pre: got hw_ready=%b, required 1", hw_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({hw_ready, busy, rsp_valid, rsp_data, rsp_timeout, hw_addr, hw_data_in, hw_sel,
         hw_write, cmd_ready} !== '0) begin
      bad++;
      $display("FAIL mid_async: got hrdy=%b busy=%b addr=%h, required all zero",
               hw_ready, busy, hw_addr);
    end
    exp_q.delete();
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) rv++;
    end
    total++;
    if (rv != 0) begin bad++; $display("FAIL mid_no_rsp: got %0d strobes, required 0", rv); end
    rmode = RNormal;
    issue(1'b1, 28'h1, 32'h1, 4'h1, 32'h0, 1'b0, acc, ok);
    run_obs(acc, 1'b1, 28'h1, 32'h1, 4'h1, rel, rc, st);
    total++;
    if (rel != 5) begin bad++; $display("FAIL mid_next_cmd: got latency %0d, required 5", rel); end
  endtask

  task automatic test_back_to_back();
    int n_acc, last;
    bit spacing_ok;
    exp_t e;
    rmode = RNormal;
    rdata = 32'h1234_5678;
    e.data = 32'h1234_5678;
    e.timeout = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 28'h10;
    cmd_data  = 32'h0;
    cmd_sel   = 4'hF;
    n_acc = 0;
    last = -1;
    spacing_ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (cmd_ready === 1'b1) begin
        exp_q.push_back(e);
        if (last >= 0 && cyc - last != 6) spacing_ok = 1'b0;
        last = cyc;
        n_acc++;
      end
    end
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (n_acc != 5) begin bad++; $display("FAIL b2b_count: got %0d accepts, required 5", n_acc); end
    total++;
    if (!spacing_ok) begin bad++; $display("FAIL b2b_spacing: got uneven spacing, required 6"); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ack_at_expiry();
    test_stale_ack();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending responses, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
